// File: rtl/problem_three_solver_if.sv
// rtl/problem_three_solver_if.sv - request/result bundle between a requester and the operand-recovery solver
//
// Signals (solver view):
//   start       in   request, only honoured while the solver is idle
//   s           in   function select (2 bits)
//   b           in   known operand (W bits)
//   target      in   observed result to invert (W bits)
//   busy        out  high while candidates are being swept
//   done        out  one-cycle pulse when results are valid
//   found       out  at least one candidate matched
//   a_first     out  lowest matching candidate (0 if none)
//   a_last      out  highest matching candidate (0 if none)
//   match_count out  number of matching candidates, 0..2^W (W+1 bits)
// Modports: master = requester, slave = solver.
interface problem_three_solver_if #(
    parameter int W = 8
);
    logic         start;
    logic [1:0]   s;
    logic [W-1:0] b;
    logic [W-1:0] target;
    logic         busy;
    logic         done;
    logic         found;
    logic [W-1:0] a_first;
    logic [W-1:0] a_last;
    logic [W:0]   match_count;

    modport master (
        output start, s, b, target,
        input  busy, done, found, a_first, a_last, match_count
    );

    modport slave (
        input  start, s, b, target,
        output busy, done, found, a_first, a_last, match_count
    );
endinterface

// File: rtl/problem_three_solver.sv
// rtl/problem_three_solver.sv - sweeps every operand a to find those reproducing a selector result
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    problem_three_solver_if.slave (start/s/b/target in; busy/done/found/a_first/a_last/match_count out)
// Parameter:
//   W      operand/result width, 2..10; one candidate per clock, 2^W candidates per sweep
// Optional build macro:
//   SOLVER_EARLY_EXIT_EN  when defined the sweep stops on the first matching candidate
module problem_three_solver #(
    parameter int W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    problem_three_solver_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]   state_q,    state_d;
    logic [1:0]   s_q,        s_d;
    logic [W-1:0] b_q,        b_d;
    logic [W-1:0] target_q,   target_d;
    logic [W-1:0] cnt_q,      cnt_d;
    logic         found_q,    found_d;
    logic [W-1:0] a_first_q,  a_first_d;
    logic [W-1:0] a_last_q,   a_last_d;
    logic [W:0]   count_q,    count_d;

    // Candidate evaluation: f(cnt_q, b_q) under the latched select
    logic [W+1:0] tri_a;
    logic [W+1:0] b_ext;
    logic [W+1:0] abs_diff;
    logic [W-1:0] shl_a;
    logic [W-1:0] f_val;
    logic         match;

    always_comb begin
        // 3*a and the magnitude compare stay at W+2 bits so large products do not alias
        tri_a    = {2'b00, cnt_q} + {1'b0, cnt_q, 1'b0};
        b_ext    = {2'b00, b_q};
        abs_diff = (tri_a > b_ext) ? (tri_a - b_ext) : (b_ext - tri_a);
        shl_a    = cnt_q << 2;
        f_val    = '0;
        case (s_q)
            2'd0:    f_val = shl_a + (b_q >> 2);
            2'd1:    f_val = cnt_q + (b_q << 1);
            2'd2:    f_val = '0 - b_q;
            default: f_val = abs_diff[W-1:0];
        endcase
        match = (f_val == target_q);
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        b_d       = b_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        found_d   = found_q;
        a_first_d = a_first_q;
        a_last_d  = a_last_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    s_d       = bus.s;
                    b_d       = bus.b;
                    target_d  = bus.target;
                    cnt_d     = '0;
                    found_d   = 1'b0;
                    a_first_d = '0;
                    a_last_d  = '0;
                    count_d   = '0;
                    state_d   = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (match) begin
                    count_d  = count_q + (W+1)'(1);
                    a_last_d = cnt_q;
                    if (!found_q) begin
                        a_first_d = cnt_q;
                        found_d   = 1'b1;
                    end
                end
                // Last candidate ends the sweep; the counter is not advanced past it
                if (&cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
`ifdef SOLVER_EARLY_EXIT_EN
                if (match) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            b_q       <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            found_q   <= 1'b0;
            a_first_q <= '0;
            a_last_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            b_q       <= b_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            found_q   <= found_d;
            a_first_q <= a_first_d;
            a_last_q  <= a_last_d;
            count_q   <= count_d;
        end
    end

    // busy/done come straight from the state register, so reset drops them asynchronously
    assign bus.busy        = (state_q == ST_SWEEP);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.found       = found_q;
    assign bus.a_first     = a_first_q;
    assign bus.a_last      = a_last_q;
    assign bus.match_count = count_q;

endmodule
